// File: rtl/io_in_conditioner.sv
// Pad input conditioner: synchronises and debounces io_in, emits clean levels and
// one-cycle edge pulses, and exposes debounce config / pin state / sticky edges over Wishbone.
module io_in_conditioner #(
    parameter int                    WIDTH            = 38,
    parameter int                    SYNC_STAGES      = 2,
    parameter int                    DEBOUNCE_W       = 16,
    parameter logic [DEBOUNCE_W-1:0] DEFAULT_DEBOUNCE = DEBOUNCE_W'(1000),
    parameter logic [31:0]           address_debounce = 32'h3000000C,
    parameter logic [31:0]           address_state0   = 32'h30000010,
    parameter logic [31:0]           address_state1   = 32'h30000014,
    parameter logic [31:0]           address_edge0    = 32'h30000018,
    parameter logic [31:0]           address_edge1    = 32'h3000001C
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_clean,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o
);

    logic [WIDTH-1:0]      sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]      s;
    logic [DEBOUNCE_W-1:0] cnt_q [WIDTH];
    logic [DEBOUNCE_W-1:0] cnt_d [WIDTH];
    logic [DEBOUNCE_W-1:0] debounce_q, debounce_d, limit;
    logic [WIDTH-1:0]      clean_q, clean_d, rise_q, rise_d, fall_q, fall_d;
    logic [WIDTH-1:0]      edge_q, edge_d, clr;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d, rdata;
    logic [63:0]           clean_ext, edge_ext;
    logic                  valid, hit_dec, hit, wr_en;
    logic                  sel_deb, sel_e0, sel_e1;

    assign s        = sync_q[SYNC_STAGES-1];
    assign io_clean = clean_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // N = max(DEBOUNCE,1); comparing with >= lets a shrunk DEBOUNCE release an in-flight count at once.
    assign limit = (debounce_q == '0) ? '0 : debounce_q - DEBOUNCE_W'(1);

    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= limit) begin
                clean_d[i] = s[i];
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
            end
        end
    end

    assign clean_ext = 64'(clean_q);
    assign edge_ext  = 64'(edge_q);
    assign valid     = wbs_cyc_i & wbs_stb_i;

    always_comb begin
        hit_dec = 1'b1;
        sel_deb = 1'b0;
        sel_e0  = 1'b0;
        sel_e1  = 1'b0;
        rdata   = '0;
        case (wbs_adr_i)
            address_debounce: begin sel_deb = 1'b1; rdata = 32'(debounce_q); end
            address_state0:   rdata = clean_ext[31:0];
            address_state1:   rdata = clean_ext[63:32];
            address_edge0:    begin sel_e0 = 1'b1; rdata = edge_ext[31:0]; end
            address_edge1:    begin sel_e1 = 1'b1; rdata = edge_ext[63:32]; end
            default:          hit_dec = 1'b0;
        endcase
    end

    // !ack_q keeps a request held across the ack cycle from being acked twice.
    assign hit   = valid & hit_dec & ~ack_q;
    assign wr_en = hit & wbs_we_i & (wbs_sel_i == 4'hF);
    assign ack_d = hit;
    assign dat_d = (hit && !wbs_we_i) ? rdata : 32'h0;

    always_comb begin
        clr = '0;
        if (wr_en && sel_e0)      clr = WIDTH'(wbs_dat_i);
        else if (wr_en && sel_e1) clr = WIDTH'({wbs_dat_i, 32'h0});
    end

    // Set wins over a same-cycle clear so no edge is ever lost.
    assign edge_d     = (edge_q & ~clr) | rise_q | fall_q;
    assign debounce_d = (wr_en && sel_deb) ? wbs_dat_i[DEBOUNCE_W-1:0] : debounce_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            clean_q    <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            edge_q     <= '0;
            debounce_q <= DEFAULT_DEBOUNCE;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            clean_q    <= clean_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            edge_q     <= edge_d;
            debounce_q <= debounce_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

endmodule

// File: doc/io_in_conditioner.md
# io_in_conditioner

Input-conditioning stage directly upstream of the multi-project harness: samples the raw `io_in` pads, synchronises them into the Wishbone clock domain, debounces every bit and presents clean levels plus single-cycle edge pulses on `io_clean`, which replaces raw `io_in` at the harness input. It also exposes a small Wishbone slave for debounce configuration, live pin state and sticky edge flags. The block sits in the user area beside the harness; the top level ORs its `wbs_ack_o` with the harness ack and selects read data by address.

## Interface

Parameters:
- `WIDTH`, 38: number of pads conditioned.
- `SYNC_STAGES`, 2: synchroniser depth, minimum 2.
- `DEBOUNCE_W`, 16: debounce counter width.
- `DEFAULT_DEBOUNCE`, 16'd1000: reset value of the DEBOUNCE register.
- `address_debounce`, 32'h3000000C: DEBOUNCE register, RW, bits [DEBOUNCE_W-1:0].
- `address_state0`, 32'h30000010: STATE0 register, RO, `io_clean[31:0]`.
- `address_state1`, 32'h30000014: STATE1 register, RO, `io_clean[WIDTH-1:32]`.
- `address_edge0`, 32'h30000018: EDGE0 register, sticky edge flags [31:0], write-1-to-clear.
- `address_edge1`, 32'h3000001C: EDGE1 register, sticky edge flags [WIDTH-1:32], write-1-to-clear.

Ports:
- `clk` input 1: Wishbone clock (`wb_clk_i`).
- `reset_n` input 1: asynchronous, active-low reset.
- `io_in` input WIDTH: raw pad inputs, asynchronous.
- `io_clean` output WIDTH: debounced levels, registered.
- `rise_o` output WIDTH: one-cycle pulse per bit on a clean 0→1 transition.
- `fall_o` output WIDTH: one-cycle pulse per bit on a clean 1→0 transition.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` input 1 each: Wishbone strobe, cycle and write enable.
- `wbs_sel_i` input 4: byte selects.
- `wbs_adr_i`, `wbs_dat_i` input 32 each: Wishbone address and write data.
- `wbs_ack_o` output 1: acknowledge.
- `wbs_dat_o` output 32: read data, zero except during a read ack.

## Operation

- Reset (async assert, sync release) clears all synchroniser flops, `io_clean`, `rise_o`, `fall_o`, per-bit counters, edge flags, `wbs_ack_o` and `wbs_dat_o` to 0. DEBOUNCE resets to `DEFAULT_DEBOUNCE`.
- Synchroniser: each bit passes through a `SYNC_STAGES` flop chain; `s[i]` is the last stage.
- Per-bit debounce uses counter `cnt[i]` (`DEBOUNCE_W` bits). `N = max(DEBOUNCE, 1)`. Each cycle:
  - if `s[i] == io_clean[i]`: `cnt[i] <= 0`.
  - else if `cnt[i] == N-1`: `io_clean[i] <= s[i]`, `cnt[i] <= 0`.
  - else: `cnt[i] <= cnt[i] + 1`.
- A glitch shorter than N cycles resets the counter and never reaches `io_clean`.
- `rise_o[i]` / `fall_o[i]` are registered in the same cycle `io_clean[i]` updates and are high for exactly one cycle.
- Sticky edge flag `edge[i]` sets on `rise_o[i] | fall_o[i]`. A W1C write clears the flags whose write-data bits are 1.
- Simultaneous set and clear on the same bit: set wins.
- Pins held high through reset produce a rise event once the debounce completes after release. This is intended.
- Changing DEBOUNCE mid-count: the new N applies immediately. If `cnt >= N-1` on the next compare, the bit updates that cycle (use `>=` in the compare).

Wishbone:
- `valid = cyc & stb`.
- Only the five decoded addresses are acked; all other addresses are ignored with no ack.
- Writes take effect only when `wbs_sel_i == 4'hF`. Partial writes are acked but ignored.
- Writes to STATE0/STATE1 are acked and ignored.
- Reads return data zero-extended; unused upper bits of EDGE1/STATE1 read 0.

## Timing

- Ack: registered, asserted the cycle after `valid` on a decoded address, high for one cycle. The ack condition includes `!wbs_ack_o`, so a held request is not double-acked. `wbs_dat_o` is valid in the ack cycle and returns to 0 the next cycle.
- Latency, pad edge held stable → `io_clean`: `SYNC_STAGES + N` clock edges.
- A DEBOUNCE write takes effect the cycle after its ack.
- A read of EDGEx in the same cycle an edge occurs returns the pre-set value; the flag is visible on the next read.
- An async reset mid-transaction drops the ack immediately. The master must restart the transaction.

## Test plan

- Reset with `io_in = 0` → all outputs 0. Read DEBOUNCE → ack one cycle later, data 1000.
- Write DEBOUNCE = 4, then raise `io_in[10]` and hold → `io_clean[10]` rises exactly 6 edges later with a one-cycle `rise_o[10]`. Read STATE0 → 0x00000400.
- With DEBOUNCE = 4, pulse `io_in[12]` high for 3 cycles → `io_clean[12]` and `rise_o[12]` stay 0 and the EDGE0 read is 0.
- Toggle `io_in[33]` up then down, each held ≥ 6 cycles → EDGE1 reads 0x2. Write EDGE1 = 0x2 → the next read returns 0. Repeat with the write landing in the same cycle as a new edge → the flag remains set.
- Write DEBOUNCE = 0 → `io_clean` follows `io_in` with 3-cycle latency. A partial write (`sel = 4'h1`) of 7 is acked and DEBOUNCE stays 0.
- Read address 0x30000020 → no ack. Hold `stb`/`cyc` for 3 cycles on STATE0 → exactly one ack pulse.
